// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: controller states and the
// address-split width helpers used by the top level and the way storage.
package dcache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Number of index bits for a power-of-two set count.
   function automatic int index_width(input int sets);
      return $clog2(sets);
   endfunction

   // Tag bits: whatever remains above the index and the 2-bit byte offset.
   function automatic int tag_width(input int addr_width, input int sets);
      return addr_width - 2 - $clog2(sets);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid bits, tag and data storage for every set,
// plus the combinational tag compare for the set being looked up.
module dcache_way
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8,
   localparam int IDX_W     = index_width(SETS),
   localparam int TAG_W     = tag_width(ADDR_WIDTH, SETS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      lookup_index,
   input  logic [TAG_W-1:0]      lookup_tag,
   output logic                  hit,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  fill_en,
   input  logic                  upd_en,
   input  logic [IDX_W-1:0]      wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] upd_mask
);

   logic [SETS-1:0]       valid_reg;
   logic [TAG_W-1:0]      tag_mem  [SETS];
   logic [DATA_WIDTH-1:0] data_mem [SETS];

   // Lookup is asynchronous so a load hit returns data in its issue cycle.
   assign valid = valid_reg[lookup_index];
   assign rdata = data_mem[lookup_index];
   assign hit   = valid && (tag_mem[lookup_index] == lookup_tag);

   // Valid bits: cleared by reset, set when a fill lands in this way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else if (fill_en) begin
         valid_reg[wr_index] <= 1'b1;
      end
   end

   // Tag/data storage: fills replace the whole line, store hits merge lanes.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end else if (upd_en) begin
         data_mem[wr_index] <= (data_mem[wr_index] & ~upd_mask) | (wr_data & upd_mask);
      end
   end

endmodule

// File: rtl/data_cache.sv
// Blocking write-through, no-write-allocate data cache with one-word lines,
// 1- or 2-way associativity, LRU replacement and hit/miss counters.
module data_cache
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8,
   parameter int WAYS       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic                  req_we_i,
   input  logic                  req_byte_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic                  mem_byte_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);

   localparam int IDX_W = index_width(SETS);
   localparam int TAG_W = tag_width(ADDR_WIDTH, SETS);

   state_t state_reg, state_next;

   logic                  mem_req_reg, mem_we_reg, mem_byte_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [DATA_WIDTH-1:0] mem_wdata_reg;
   logic                  way_reg;       // way to fill, or way that hit at store issue
   logic                  line_hit_reg;  // store found its line resident at issue
   logic                  replay_reg;    // next IDLE access is the post-fill replay
   logic [31:0]           hit_cnt_reg, miss_cnt_reg;

   logic                  issue, fill_done, write_done, count_en;
   logic                  hit, hit_way, victim;
   logic [DATA_WIDTH-1:0] hit_word;
   logic [7:0]            byte_sel;
   logic                  lru_touch, lru_way;
   logic [IDX_W-1:0]      lru_index;

   logic [IDX_W-1:0]      req_index, wr_index;
   logic [TAG_W-1:0]      req_tag, wr_tag;
   logic [1:0]            wr_lane;
   logic [DATA_WIDTH-1:0] wr_data, upd_mask;

   logic [WAYS-1:0]       way_hit, way_valid, fill_en, upd_en;
   logic [DATA_WIDTH-1:0] way_rdata [WAYS];

   // Lookup uses the live CPU address; writes into the arrays use the
   // address captured at issue, which is also what memory is being sent.
   assign req_index = addr_i[IDX_W+1:2];
   assign req_tag   = addr_i[ADDR_WIDTH-1:IDX_W+2];
   assign wr_index  = mem_addr_reg[IDX_W+1:2];
   assign wr_tag    = mem_addr_reg[ADDR_WIDTH-1:IDX_W+2];
   assign wr_lane   = mem_addr_reg[1:0];

   assign wr_data  = (state_reg == ST_FILL) ? mem_rdata_i :
                     mem_byte_reg ? (DATA_WIDTH'(mem_wdata_reg[7:0]) << {wr_lane, 3'b000}) :
                     mem_wdata_reg;
   assign upd_mask = mem_byte_reg ? (DATA_WIDTH'(8'hFF) << {wr_lane, 3'b000}) : '1;

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign fill_en[gi] = fill_done && (way_reg == 1'(gi));
         assign upd_en[gi]  = write_done && line_hit_reg && (way_reg == 1'(gi));

         dcache_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .SETS       (SETS)
         ) u_way (
            .clk          (clk),
            .rst          (rst),
            .lookup_index (req_index),
            .lookup_tag   (req_tag),
            .hit          (way_hit[gi]),
            .valid        (way_valid[gi]),
            .rdata        (way_rdata[gi]),
            .fill_en      (fill_en[gi]),
            .upd_en       (upd_en[gi]),
            .wr_index     (wr_index),
            .wr_tag       (wr_tag),
            .wr_data      (wr_data),
            .upd_mask     (upd_mask)
         );
      end
   endgenerate

   // Merge the per-way compare results into one hit flag, way and word.
   always_comb begin
      hit      = 1'b0;
      hit_way  = 1'b0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w]) begin
            hit      = 1'b1;
            hit_way  = 1'(w);
            hit_word = way_rdata[w];
         end
      end
   end

   assign byte_sel = 8'(hit_word >> {addr_i[1:0], 3'b000});
   assign rdata_o  = req_byte_i ? DATA_WIDTH'(byte_sel) : hit_word;

   // Recency is refreshed by any hit seen in IDLE and by every fill.
   assign lru_touch = ((state_reg == ST_IDLE) && req_valid_i && hit) || fill_done;
   assign lru_way   = fill_done ? way_reg : hit_way;
   assign lru_index = fill_done ? wr_index : req_index;

   generate
      if (WAYS == 2) begin : g_lru
         logic [SETS-1:0] lru_reg;  // per set: which way is least recently used

         // Point the set's LRU bit at the way that was not just used.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lru_reg <= '0;
            end else if (lru_touch) begin
               lru_reg[lru_index] <= ~lru_way;
            end
         end

         assign victim = !way_valid[0] ? 1'b0 :
                         !way_valid[1] ? 1'b1 : lru_reg[req_index];
      end else begin : g_direct
         assign victim = 1'b0;
      end
   endgenerate

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, stall and the issue/completion strobes.
   always_comb begin
      state_next = state_reg;
      stall_o    = 1'b0;
      issue      = 1'b0;
      fill_done  = 1'b0;
      write_done = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid_i && (req_we_i || !hit)) begin
               stall_o    = 1'b1;
               issue      = 1'b1;
               state_next = req_we_i ? ST_WRITE : ST_FILL;
            end
         end
         ST_FILL: begin
            stall_o = 1'b1;
            if (mem_ack_i) begin
               fill_done  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (mem_ack_i) begin
               write_done = 1'b1;
               state_next = ST_IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Capture the memory request at issue and hold it until acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_byte_reg  <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         way_reg       <= 1'b0;
         line_hit_reg  <= 1'b0;
      end else if (issue) begin
         mem_req_reg   <= 1'b1;
         mem_we_reg    <= req_we_i;
         mem_byte_reg  <= req_we_i & req_byte_i;
         mem_addr_reg  <= req_we_i ? addr_i : {addr_i[ADDR_WIDTH-1:2], 2'b00};
         mem_wdata_reg <= req_we_i ? wdata_i : '0;
         way_reg       <= hit ? hit_way : victim;
         line_hit_reg  <= hit;
      end else if (fill_done || write_done) begin
         mem_req_reg <= 1'b0;
      end
   end

   assign mem_req_o   = mem_req_reg;
   assign mem_we_o    = mem_we_reg;
   assign mem_byte_o  = mem_byte_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_wdata_o = mem_wdata_reg;

   // The load that completes a fill is the one already counted as a miss.
   assign count_en = (state_reg == ST_IDLE) && req_valid_i && !(replay_reg && hit && !req_we_i);

   // Replay flag and saturating hit/miss counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         replay_reg   <= 1'b0;
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else begin
         if (fill_done) begin
            replay_reg <= 1'b1;
         end else if ((state_reg == ST_IDLE) && req_valid_i) begin
            replay_reg <= 1'b0;
         end
         if (count_en && hit && (hit_cnt_reg != '1)) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end
         if (count_en && !hit && (miss_cnt_reg != '1)) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_reg;
   assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a recency-ordered list of resident lines per set and
// a word-addressed memory form the reference; a per-cycle compare process
// checks stall, load data, counters and memory requests against it.
module tb_data_cache;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int SETS = 8;
   localparam int WAYS = 2;
   localparam int LAT  = 3;   // memory acks in the 3rd cycle of a request

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_i = 1'b0, req_we_i = 1'b0, req_byte_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] wdata_i = '0;
   logic [DW-1:0] rdata_o;
   logic          stall_o, mem_req_o, mem_we_o, mem_byte_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          mem_ack_r = 1'b0, spur_ack = 1'b0, mem_ack_i;
   logic [31:0]   hit_cnt_o, miss_cnt_o;

   assign mem_ack_i = mem_ack_r | spur_ack;

   data_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_byte_i(req_byte_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_byte_o(mem_byte_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [29:0]  lines [SETS][$];          // resident line numbers, most recent first
   logic [31:0]  mem [logic [29:0]];       // backing memory, by word address
   int unsigned  model_hit = 0, model_miss = 0;

   // Current transaction expectations
   bit          txn_active = 1'b0, need_mem = 1'b0, cur_we = 1'b0, chk_en = 1'b0, exp_mreq;
   int          txn_cyc = 0, exp_stall = 0;
   logic [31:0] exp_rdata = '0, exp_maddr = '0, exp_mwdata = '0;
   bit          exp_mwe = 1'b0, exp_mbyte = 1'b0;

   int          n_checks = 0, n_fail = 0;
   int          age = 0, ack_count = 0;
   logic [31:0] last_mem_addr = '0;
   logic        last_mem_byte = 1'b0;
   int          obs_stall = 0, obs_mem_reqs = 0;
   logic [31:0] obs_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [29:0] w);
      if (mem.exists(w)) return mem[w];
      return {w[15:0], ~w[15:0]};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) lines[s].delete();
      model_hit  = 0;
      model_miss = 0;
   endtask

   // Backing memory: acknowledges the LAT-th cycle of each request.
   always @(posedge clk) begin
      #1;
      if (mem_req_o) age++;
      else age = 0;
      mem_ack_r = 1'b0;
      if (mem_req_o && age == LAT) begin
         logic [31:0] v;
         mem_ack_r     = 1'b1;
         ack_count++;
         last_mem_addr = mem_addr_o;
         last_mem_byte = mem_byte_o;
         v = mem_read(mem_addr_o[31:2]);
         if (mem_we_o) begin
            if (mem_byte_o) v[{mem_addr_o[1:0], 3'b000} +: 8] = mem_wdata_o[7:0];
            else v = mem_wdata_o;
            mem[mem_addr_o[31:2]] = v;
         end else begin
            mem_rdata_i = v;
         end
      end
   end

   // Per-cycle comparison against the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("hit_cnt", hit_cnt_o, model_hit);
         chk("miss_cnt", miss_cnt_o, model_miss);
         if (txn_active) begin
            chk("stall", 32'(stall_o), 32'(txn_cyc < exp_stall));
            if (!cur_we && txn_cyc == exp_stall) chk("rdata", rdata_o, exp_rdata);
         end else begin
            chk("stall_idle", 32'(stall_o), 32'd0);
         end
         exp_mreq = txn_active && need_mem && txn_cyc >= 1 && txn_cyc <= LAT;
         chk("mem_req", 32'(mem_req_o), 32'(exp_mreq));
         if (mem_req_o && exp_mreq) begin
            chk("mem_addr", mem_addr_o, exp_maddr);
            chk("mem_we", 32'(mem_we_o), 32'(exp_mwe));
            chk("mem_byte", 32'(mem_byte_o), 32'(exp_mbyte));
            if (cur_we) chk("mem_wdata", mem_wdata_o, exp_mwdata);
         end
      end
   end

   // One CPU access; called just after a rising edge, returns one cycle after completion.
   task automatic access(input bit we, input bit bt, input logic [31:0] addr, input logic [31:0] wd);
      logic [29:0] line;
      logic [31:0] w;
      int          set_i, pos, ack0;
      bit          hit;
      line  = addr[31:2];
      set_i = int'(line) % SETS;
      hit   = 1'b0;
      pos   = -1;
      for (int k = 0; k < lines[set_i].size(); k++)
         if (lines[set_i][k] == line) begin hit = 1'b1; pos = k; end
      w          = mem_read(line);
      exp_rdata  = bt ? {24'h0, w[{addr[1:0], 3'b000} +: 8]} : w;
      cur_we     = we;
      need_mem   = we || !hit;
      exp_stall  = we ? LAT : (hit ? 0 : LAT + 1);
      exp_maddr  = we ? addr : {addr[31:2], 2'b00};
      exp_mwe    = we;
      exp_mbyte  = we && bt;
      exp_mwdata = wd;
      if (hit) begin
         lines[set_i].delete(pos);
         lines[set_i].push_front(line);
      end else if (!we) begin
         lines[set_i].push_front(line);
         if (lines[set_i].size() > WAYS) void'(lines[set_i].pop_back());
      end
      req_valid_i = 1'b1; req_we_i = we; req_byte_i = bt; addr_i = addr; wdata_i = wd;
      txn_cyc = 0; txn_active = 1'b1; obs_stall = 0; ack0 = ack_count;
      for (int c = 0; c <= exp_stall; c++) begin
         @(negedge clk);
         if (stall_o) obs_stall++;
         if (c == exp_stall) obs_rdata = rdata_o;
         @(posedge clk); #1;
         if (c == 0) begin
            if (hit) model_hit++;
            else model_miss++;
         end
         txn_cyc = c + 1;
      end
      req_valid_i = 1'b0; txn_active = 1'b0;
      obs_mem_reqs = ack_count - ack0;
      $display("access we=%0d byte=%0d addr=0x%08h %s stall=%0d rdata=0x%08h memreqs=%0d",
               we, bt, addr, hit ? "hit" : "miss", obs_stall, obs_rdata, obs_mem_reqs);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; model_reset();
      @(posedge clk); #1; chk_en = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ta [8];
      mem[30'h40] = 32'hDEADBEEF;   // word at 0x100
      model_reset();
      #12;
      chk("rst_hit_cnt", hit_cnt_o, 32'd0);
      chk("rst_miss_cnt", miss_cnt_o, 32'd0);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1; chk_en = 1'b1;

      // Cold load miss, then hit
      access(0, 0, 32'h100, 0);
      chk("cold_stall", obs_stall, 32'd4);
      chk("cold_rdata", obs_rdata, 32'hDEADBEEF);
      chk("cold_miss", miss_cnt_o, 32'd1);
      chk("cold_hit", hit_cnt_o, 32'd0);
      access(0, 0, 32'h100, 0);
      chk("rehit_stall", obs_stall, 32'd0);
      chk("rehit_rdata", obs_rdata, 32'hDEADBEEF);
      chk("rehit_cnt", hit_cnt_o, 32'd1);

      // Byte store on a resident line
      access(1, 1, 32'h101, 32'h55);
      chk("bst_stall", obs_stall, 32'd3);
      chk("bst_memreqs", obs_mem_reqs, 32'd1);
      chk("bst_byte", 32'(last_mem_byte), 32'd1);
      chk("bst_addr", last_mem_addr, 32'h101);
      access(0, 0, 32'h100, 0);
      chk("bst_word", obs_rdata, 32'hDEAD55EF);
      chk("bst_nomem", obs_mem_reqs, 32'd0);
      access(0, 1, 32'h101, 0);
      chk("bld_lane1", obs_rdata, 32'h55);
      access(0, 1, 32'h103, 0);
      chk("bld_lane3", obs_rdata, 32'hDE);
      chk("hits_5", hit_cnt_o, 32'd5);

      // Stray ack while idle must be ignored
      spur_ack = 1'b1; @(posedge clk); #1; spur_ack = 1'b0;
      @(posedge clk); #1;

      // Store miss: one write, no allocation
      access(1, 0, 32'h200, 32'h12345678);
      chk("smiss_memreqs", obs_mem_reqs, 32'd1);
      access(0, 0, 32'h200, 0);
      chk("smiss_reload", obs_stall, 32'd4);
      chk("smiss_rdata", obs_rdata, 32'h12345678);

      // LRU eviction in set 0
      do_reset();
      chk("rst2_hit", hit_cnt_o, 32'd0);
      chk("rst2_miss", miss_cnt_o, 32'd0);
      access(0, 0, 32'h100, 0);
      access(0, 0, 32'h120, 0);
      access(0, 0, 32'h100, 0);
      access(0, 0, 32'h140, 0);
      access(0, 0, 32'h100, 0);
      chk("lru_keep", obs_stall, 32'd0);
      chk("lru_keep_data", obs_rdata, 32'hDEAD55EF);
      access(0, 0, 32'h120, 0);
      chk("lru_evicted", obs_stall, 32'd4);
      chk("lru_hits", hit_cnt_o, 32'd2);
      chk("lru_misses", miss_cnt_o, 32'd4);

      // Word store hit updates the cached line
      access(1, 0, 32'h120, 32'hCAFEF00D);
      access(0, 0, 32'h120, 0);
      chk("wst_stall", obs_stall, 32'd0);
      chk("wst_rdata", obs_rdata, 32'hCAFEF00D);

      // Replacement walk in set 5 with mixed word/byte loads
      ta = '{32'h014, 32'h034, 32'h016, 32'h054, 32'h034, 32'h014, 32'h017, 32'h054};
      for (int i = 0; i < 8; i++) access(0, ta[i][1:0] != 2'b00, ta[i], 0);

      // Reset in the middle of a fill
      do_reset();
      chk_en = 1'b0;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_byte_i = 1'b0; addr_i = 32'h300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fill_mreq", 32'(mem_req_o), 32'd1);
      rst = 1'b1; req_valid_i = 1'b0; #1;
      chk("fill_rst_mreq", 32'(mem_req_o), 32'd0);
      chk("fill_rst_stall", 32'(stall_o), 32'd0);
      @(negedge clk); rst = 1'b0; model_reset();
      @(posedge clk); #1; chk_en = 1'b1;
      access(0, 0, 32'h300, 0);
      chk("fill_rst_remiss", obs_stall, 32'd4);
      chk("fill_rst_misscnt", miss_cnt_o, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
